// File: rtl/seq_111010_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_111010_gen
// Purpose  : Serial frame generator: sends PATTERN MSB-first for a burst of
//            `count` frames with GAP idle cycles between frames.
// Revision : 1.0 - initial release
// ============================================================================
module seq_111010_gen #(
    parameter logic [5:0]  PATTERN = 6'b111010,
    parameter int unsigned GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] count,
    input  logic       abort,
    output logic       x,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] frames_sent
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // shreg holds the bits still to be shown; x_q already carries the current one
    localparam logic [5:0] c_shreg_load = {PATTERN[4:0], 1'b0};
    localparam logic [3:0] c_gap_load   = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam bit         c_no_gap     = (GAP == 0);

    state_t     state_q,     state_d;
    logic [5:0] shreg_q,     shreg_d;
    logic [2:0] bit_idx_q,   bit_idx_d;
    logic [7:0] remaining_q, remaining_d;
    logic [3:0] gap_cnt_q,   gap_cnt_d;
    logic [7:0] frames_q,    frames_d;
    logic       x_q,         x_d;
    logic       valid_q,     valid_d;
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        frames_d    = frames_q;
        x_d         = 1'b0;
        valid_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (count != 8'd0)) begin
                    state_d     = S_SHIFT;
                    remaining_d = count;
                    frames_d    = 8'd0;
                    shreg_d     = c_shreg_load;
                    bit_idx_d   = 3'd0;
                    x_d         = PATTERN[5];
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_idx_q != 3'd5) begin
                    x_d       = shreg_q[5];
                    shreg_d   = {shreg_q[4:0], 1'b0};
                    bit_idx_d = bit_idx_q + 3'd1;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    frames_d    = frames_q + 8'd1;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (c_no_gap) begin
                        shreg_d   = c_shreg_load;
                        bit_idx_d = 3'd0;
                        x_d       = PATTERN[5];
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = c_gap_load;
                        busy_d    = 1'b1;
                    end
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == 4'd0) begin
                    state_d   = S_SHIFT;
                    shreg_d   = c_shreg_load;
                    bit_idx_d = 3'd0;
                    x_d       = PATTERN[5];
                    valid_d   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over frame completion: an interrupted frame is never counted
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            frames_d    = frames_q;
            remaining_d = remaining_q;
            x_d         = 1'b0;
            valid_d     = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= 6'd0;
            bit_idx_q   <= 3'd0;
            remaining_q <= 8'd0;
            gap_cnt_q   <= 4'd0;
            frames_q    <= 8'd0;
            x_q         <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
            frames_q    <= frames_d;
            x_q         <= x_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign x           = x_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_q;

endmodule
`default_nettype wire
